// File: rtl/minitb_ahb_slave_mem.sv
// AHB-Lite slave memory: word-addressed, programmable wait states, two-cycle ERROR for
// out-of-range addresses, read-after-write forwarding and transfer counters.
module minitb_ahb_slave_mem #(
  parameter int unsigned addrWidth   = 8,
  parameter int unsigned dataWidth   = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 hsel,
  input  logic [1:0]           htrans,
  input  logic [addrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [dataWidth-1:0] hwdata,
  output logic                 hready,
  output logic [1:0]           hresp,
  output logic [dataWidth-1:0] hrdata,
  output logic [15:0]          wr_count,
  output logic [7:0]           err_count
);

  localparam int unsigned         IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [addrWidth:0]  DepthLim = (addrWidth + 1)'(DEPTH);
  localparam logic [3:0]          WaitInit = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StAddr, StWait, StErr1, StErr2} state_e;

  state_e               state_q, state_d;
  logic                 dphase_q, dphase_d;
  logic [IdxW-1:0]      addr_q, addr_d;
  logic                 write_q, write_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 hready_q, hready_d;
  logic [1:0]           hresp_q, hresp_d;
  logic [dataWidth-1:0] hrdata_q, hrdata_d;
  logic [15:0]          wr_cnt_q, wr_cnt_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic [dataWidth-1:0] mem_q [DEPTH];
  logic [dataWidth-1:0] mem_d [DEPTH];

  logic            accept;
  logic            in_range;
  logic            commit;
  logic [IdxW-1:0] haddr_idx;

  always_comb begin
    accept    = hsel && htrans[1] && hready_q;
    in_range  = ({1'b0, haddr} < DepthLim);
    haddr_idx = haddr[IdxW-1:0];
    // Only in-range data phases set dphase_q, and they end in StAddr with hready high.
    commit    = dphase_q && write_q && hready_q;

    state_d   = state_q;
    dphase_d  = dphase_q;
    addr_d    = addr_q;
    write_d   = write_q;
    cnt_d     = cnt_q;
    hrdata_d  = hrdata_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    mem_d     = mem_q;

    if (commit) begin
      mem_d[addr_q] = hwdata;
      wr_cnt_d      = wr_cnt_q + 16'd1;
    end

    case (state_q)
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StAddr;
      end
      StErr1:  state_d = StErr2;
      StErr2:  state_d = StAddr;
      default: state_d = StAddr;
    endcase

    if (hready_q) dphase_d = 1'b0;

    if (accept) begin
      addr_d  = haddr_idx;
      write_d = hwrite;
      if (!in_range) begin
        state_d = StErr1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        dphase_d = 1'b1;
        if (WaitInit != 4'd0) begin
          state_d = StWait;
          cnt_d   = WaitInit;
        end else begin
          state_d = StAddr;
        end
        // A write committing to the same word at this edge wins over the stored value.
        if (!hwrite) hrdata_d = (commit && (addr_q == haddr_idx)) ? hwdata : mem_q[haddr_idx];
      end
    end

    hready_d = !((state_d == StWait) || (state_d == StErr1));
    hresp_d  = ((state_d == StErr1) || (state_d == StErr2)) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= StAddr;
      dphase_q  <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      hready_q  <= 1'b1;
      hresp_q   <= 2'b00;
      hrdata_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      dphase_q  <= dphase_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      hrdata_q  <= hrdata_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
      mem_q     <= mem_d;
    end
  end

  assign hready    = hready_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;
  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_minitb_ahb_slave_mem.sv
// Bench for minitb_ahb_slave_mem: two instances (0 and 2 wait states) driven by a pipelined
// AHB master task and checked against a transfer-level memory model.
module tb_minitb_ahb_slave_mem;

  localparam int Depth = 16;
  localparam int Ws0   = 0;
  localparam int Ws1   = 2;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
  } vec_t;

  logic        clk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel      [2];
  logic [1:0]  htrans    [2];
  logic [7:0]  haddr     [2];
  logic        hwrite    [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic [1:0]  hresp     [2];
  logic [31:0] hrdata    [2];
  logic [15:0] wr_count  [2];
  logic [7:0]  err_count [2];

  always #5 clk = ~clk;

  minitb_ahb_slave_mem #(.addrWidth(8), .dataWidth(32), .DEPTH(Depth), .WAIT_STATES(Ws0)) u_dut0 (
    .hclk(clk), .hresetn(hresetn), .hsel(hsel[0]), .htrans(htrans[0]), .haddr(haddr[0]),
    .hwrite(hwrite[0]), .hwdata(hwdata[0]), .hready(hready[0]), .hresp(hresp[0]),
    .hrdata(hrdata[0]), .wr_count(wr_count[0]), .err_count(err_count[0])
  );

  minitb_ahb_slave_mem #(.addrWidth(8), .dataWidth(32), .DEPTH(Depth), .WAIT_STATES(Ws1)) u_dut1 (
    .hclk(clk), .hresetn(hresetn), .hsel(hsel[1]), .htrans(htrans[1]), .haddr(haddr[1]),
    .hwrite(hwrite[1]), .hwdata(hwdata[1]), .hready(hready[1]), .hresp(hresp[1]),
    .hrdata(hrdata[1]), .wr_count(wr_count[1]), .err_count(err_count[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory contents, counters and last value loaded into hrdata.
  logic [31:0] m_mem [2][Depth];
  int          m_wr  [2];
  int          m_err [2];
  logic [31:0] m_rd  [2];

  op_t ops [$];

  function automatic int ws_of(input int d);
    return (d == 0) ? Ws0 : Ws1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < Depth; i++) m_mem[d][i] = '0;
      m_wr[d]  = 0;
      m_err[d] = 0;
      m_rd[d]  = '0;
    end
  endtask

  task automatic check_cnts(input int d);
    check($sformatf("wr_count[%0d]", d), 32'(wr_count[d]), 32'(m_wr[d] % 65536));
    check($sformatf("err_count[%0d]", d), 32'(err_count[d]), 32'(m_err[d]));
  endtask

  task automatic drive_idle(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    haddr[d]  = '0;
    hwrite[d] = 1'b0;
  endtask

  task automatic drive_addr(input int d, input op_t o);
    hsel[d]   = 1'b1;
    htrans[d] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
    haddr[d]  = o.addr;
    hwrite[d] = o.wr;
  endtask

  // Issues every op in `ops` back-to-back on instance d, checking each data-phase cycle.
  task automatic run_ops(input int d, output logic [31:0] last_rd, output logic [1:0] last_resp);
    op_t         cur;
    bit          cur_v = 0;
    bit          oor = 0;
    bit          done = 0;
    bit          exp_rdy;
    int          cyc = 0;
    int          ai = 0;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rd;
    last_rd   = '0;
    last_resp = '0;
    @(posedge clk); #1;
    if (ops.size() == 0) return;
    drive_addr(d, ops[0]);
    while (!done) begin
      @(negedge clk);
      rdy  = hready[d];
      resp = hresp[d];
      rd   = hrdata[d];
      if (cur_v) begin
        exp_rdy = oor ? (cyc == 1) : (cyc >= ws_of(d));
        check($sformatf("hready[%0d] a=%0d c=%0d", d, cur.addr, cyc), 32'(rdy), 32'(exp_rdy));
        check($sformatf("hresp[%0d] a=%0d c=%0d", d, cur.addr, cyc), 32'(resp),
              oor ? 32'd1 : 32'd0);
        if (oor || (!cur.wr && exp_rdy))
          check($sformatf("hrdata[%0d] a=%0d", d, cur.addr), rd, m_rd[d]);
        if (rdy) begin
          last_rd   = rd;
          last_resp = resp;
        end
        cyc++;
        if (cyc > 40) begin
          n_checks++;
          n_errors++;
          $display("FAIL timeout[%0d]: data phase open for %0d cycles, required <= %0d",
                   d, cyc, ws_of(d) + 2);
          drive_idle(d);
          return;
        end
      end else begin
        check($sformatf("hready_idle[%0d]", d), 32'(rdy), 32'd1);
        check($sformatf("hresp_idle[%0d]", d), 32'(resp), 32'd0);
      end
      if (rdy) begin
        if (cur_v && cur.wr && !oor) begin
          m_mem[d][cur.addr[3:0]] = cur.data;
          m_wr[d] = (m_wr[d] + 1) % 65536;
        end
        if (ai < ops.size()) begin
          cur   = ops[ai];
          ai++;
          cur_v = 1;
          cyc   = 0;
          oor   = (int'(cur.addr) >= Depth);
          if (oor) begin
            if (m_err[d] < 255) m_err[d]++;
          end else if (!cur.wr) begin
            m_rd[d] = m_mem[d][cur.addr[3:0]];
          end
        end else begin
          cur_v = 0;
          done  = 1;
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        hwdata[d] = (cur_v && cur.wr) ? cur.data : $urandom();
        if (ai < ops.size()) drive_addr(d, ops[ai]);
        else drive_idle(d);
      end
    end
  endtask

  function automatic op_t mk(input bit wr, input int addr, input logic [31:0] data);
    op_t o;
    o.wr   = wr;
    o.addr = 8'(addr);
    o.data = data;
    return o;
  endfunction

  vec_t        vecs [8];
  logic [31:0] rd;
  logic [1:0]  resp;

  initial begin
    vecs[0] = '{1'b1, 8'd3,  32'hDEADBEEF, 1'b0, 32'h0,        2'b00};
    vecs[1] = '{1'b0, 8'd3,  32'h0,        1'b1, 32'hDEADBEEF, 2'b00};
    vecs[2] = '{1'b0, 8'd0,  32'h0,        1'b1, 32'h0,        2'b00};
    vecs[3] = '{1'b1, 8'd16, 32'hCAFEF00D, 1'b0, 32'h0,        2'b01};
    vecs[4] = '{1'b0, 8'd16, 32'h0,        1'b0, 32'h0,        2'b01};
    vecs[5] = '{1'b0, 8'd0,  32'h0,        1'b1, 32'h0,        2'b00};
    vecs[6] = '{1'b1, 8'd15, 32'hA5A55A5A, 1'b0, 32'h0,        2'b00};
    vecs[7] = '{1'b0, 8'd15, 32'h0,        1'b1, 32'hA5A55A5A, 2'b00};

    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      hwdata[d] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_hready[%0d]", d), 32'(hready[d]), 32'd1);
      check($sformatf("rst_hresp[%0d]", d), 32'(hresp[d]), 32'd0);
      check($sformatf("rst_hrdata[%0d]", d), hrdata[d], 32'd0);
      check_cnts(d);
    end
    @(negedge clk);
    hresetn = 1'b1;

    // Directed single transfers from the vector table.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        ops = {};
        ops.push_back(mk(vecs[i].wr, int'(vecs[i].addr), vecs[i].wdata));
        run_ops(d, rd, resp);
        check($sformatf("vec%0d_resp[%0d]", i, d), 32'(resp), 32'(vecs[i].exp_resp));
        if (vecs[i].chk_rd) check($sformatf("vec%0d_rd[%0d]", i, d), rd, vecs[i].exp_rd);
      end
      check_cnts(d);
    end

    // Back-to-back writes then reads.
    for (int d = 0; d < 2; d++) begin
      ops = {};
      ops.push_back(mk(1'b1, 0, 32'hAAAA0001));
      ops.push_back(mk(1'b1, 1, 32'hBBBB0002));
      ops.push_back(mk(1'b1, 2, 32'hCCCC0003));
      ops.push_back(mk(1'b1, 3, 32'hDDDD0004));
      for (int a = 0; a < 4; a++) ops.push_back(mk(1'b0, a, 32'h0));
      run_ops(d, rd, resp);
      check($sformatf("b2b_last_rd[%0d]", d), rd, 32'hDDDD0004);
      check_cnts(d);
    end

    // Read overlapping a write to the same word must see the new data.
    for (int d = 0; d < 2; d++) begin
      ops = {};
      ops.push_back(mk(1'b1, 5, 32'h12345678));
      ops.push_back(mk(1'b0, 5, 32'h0));
      run_ops(d, rd, resp);
      check($sformatf("fwd_rd[%0d]", d), rd, 32'h12345678);
    end

    // ERROR counter saturation.
    ops = {};
    for (int i = 0; i < 260; i++) ops.push_back(mk($urandom_range(0, 1), 16 + i % 200, i));
    run_ops(0, rd, resp);
    check("err_sat", 32'(err_count[0]), 32'd255);
    check_cnts(0);

    // IDLE, BUSY and deselected cycles must be ignored.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        hsel[d]   = (c % 3) != 0;
        htrans[d] = (c % 3 == 0) ? 2'b10 : ((c % 3 == 1) ? 2'b00 : 2'b01);
        haddr[d]  = 8'($urandom_range(0, 15));
        hwrite[d] = 1'b1;
        hwdata[d] = $urandom();
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("idle_hready[%0d]", d), 32'(hready[d]), 32'd1);
        check($sformatf("idle_hresp[%0d]", d), 32'(hresp[d]), 32'd0);
      end
    end
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      check_cnts(d);
    end

    // Randomized pipelined traffic, including out-of-range addresses.
    for (int d = 0; d < 2; d++) begin
      ops = {};
      for (int i = 0; i < 60; i++) ops.push_back(mk($urandom_range(0, 1), $urandom_range(0, 19),
                                                     $urandom()));
      run_ops(d, rd, resp);
      check_cnts(d);
    end

    // Asynchronous reset during a wait cycle of a write on the wait-state instance.
    @(posedge clk); #1;
    drive_addr(1, mk(1'b1, 7, 32'h0));
    @(posedge clk); #1;
    drive_idle(1);
    hwdata[1] = 32'h77777777;
    #2;
    check("mid_hready_low", 32'(hready[1]), 32'd0);
    hresetn = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("arst_hready[%0d]", d), 32'(hready[d]), 32'd1);
      check($sformatf("arst_hresp[%0d]", d), 32'(hresp[d]), 32'd0);
      check($sformatf("arst_hrdata[%0d]", d), hrdata[d], 32'd0);
      check_cnts(d);
    end
    @(negedge clk);
    hresetn = 1'b1;
    ops = {};
    ops.push_back(mk(1'b0, 7, 32'h0));
    ops.push_back(mk(1'b1, 7, 32'h0BADC0DE));
    ops.push_back(mk(1'b0, 7, 32'h0));
    run_ops(1, rd, resp);
    check("post_rst_rd", rd, 32'h0BADC0DE);
    check_cnts(1);

    // Full read-back of both memories.
    for (int d = 0; d < 2; d++) begin
      ops = {};
      for (int a = 0; a < Depth; a++) ops.push_back(mk(1'b0, a, 32'h0));
      run_ops(d, rd, resp);
      check_cnts(d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
